// File: rtl/popcnt_pkg.sv
// -----------------------------------------------------------------------------
// popcnt_pkg
// Shared definitions for the popcount sharing controller.
//   ADD_IN_W / ADD_OUT_W : width of one beat and of its 4-bit popcount
//   RR_MAX / RR_IDX_W    : largest requester count the round-robin helper handles
//   state_t              : controller FSM states
//   rr_pick()            : first valid index searching upward from ptr, wrapping
// -----------------------------------------------------------------------------
package popcnt_pkg;

    localparam int ADD_IN_W  = 10;
    localparam int ADD_OUT_W = 4;

    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Only the low nreq bits of valid are considered; ptr must be < nreq.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX-1:0]   valid,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  nreq
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        logic [31:0]         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < nreq) begin
                idx = 32'(ptr) + 32'(k);
                if (idx >= 32'(nreq)) begin
                    idx = idx - 32'(nreq);
                end
                if (!found && valid[idx[RR_IDX_W-1:0]]) begin
                    pick  = idx[RR_IDX_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_10to4.sv
// -----------------------------------------------------------------------------
// adder_10to4
// Combinational popcount of one 10-bit beat.
//   bits  in  10  beat data
//   count out 4   number of set bits (0..10)
// -----------------------------------------------------------------------------
module adder_10to4
    import popcnt_pkg::*;
(
    input  logic [ADD_IN_W-1:0]  bits,
    output logic [ADD_OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < ADD_IN_W; i++) begin
            count = count + ADD_OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/rr_arbiter_nreq.sv
// -----------------------------------------------------------------------------
// rr_arbiter_nreq
// Combinational round-robin pick among NREQ requesters.
//   valid     in  NREQ  request vector
//   ptr       in  ID_W  highest-priority index this round
//   winner    out ID_W  first valid index at or above ptr, wrapping
//   any_valid out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter_nreq
    import popcnt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any_valid
);

    if (NREQ > RR_MAX) begin : g_nreq_check
        $error("rr_arbiter_nreq: NREQ exceeds RR_MAX");
    end

    logic [RR_MAX-1:0]   valid_ext;
    logic [RR_IDX_W-1:0] ptr_ext;
    logic [RR_IDX_W-1:0] pick;

    assign valid_ext = RR_MAX'(valid);
    assign ptr_ext   = RR_IDX_W'(ptr);
    assign pick      = rr_pick(valid_ext, ptr_ext, NREQ);
    assign winner    = ID_W'(pick);
    assign any_valid = |valid;

endmodule

// File: rtl/popcnt_share_ctrl.sv
// -----------------------------------------------------------------------------
// popcnt_share_ctrl
// Shares one adder_10to4 popcount datapath among NREQ requesters, granted
// round-robin. A job is BEATS consecutive 10-bit beats from the granted
// requester; their popcounts are summed and returned as one tagged result.
//
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high
//   req_valid  in   NREQ       per-requester beat valid
//   req_data   in   NREQ*10    requester i at [10*i+9:10*i]
//   req_ready  out  NREQ       one-hot on the granted requester while accumulating
//   out_valid  out  1          result valid (held until out_ready)
//   out_ready  in   1          consumer accepts result
//   out_sum    out  ACC_W      set bits over the job
//   out_id     out  ID_W       requester that owned the job
//   thresh     in   ACC_W      (POPCNT_THRESH_EN only) fire threshold
//   out_fire   out  1          (POPCNT_THRESH_EN only) out_sum >= thresh
//
// Build option: define POPCNT_THRESH_EN to add the threshold compare.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitration bubble; latch winner, clear acc and beat_cnt
// ACCUM | accept beats from gnt only; stall (grant held) while invalid
// DONE  | result held on out_*; advance rr_ptr past gnt on handshake
// -----------------------------------------------------------------------------
module popcnt_share_ctrl
    import popcnt_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int BEATS = 8,
    parameter  int ACC_W = 8,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADD_IN_W-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic [ID_W-1:0]          out_id
`ifdef POPCNT_THRESH_EN
    ,
    input  logic [ACC_W-1:0]         thresh,
    output logic                     out_fire
`endif
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (ACC_W < $clog2(10 * BEATS + 1)) begin : g_acc_w_check
        $error("popcnt_share_ctrl: ACC_W too narrow for 10*BEATS");
    end
    if (NREQ < 2) begin : g_nreq_check
        $error("popcnt_share_ctrl: NREQ must be at least 2");
    end
    if (BEATS < 1) begin : g_beats_check
        $error("popcnt_share_ctrl: BEATS must be at least 1");
    end

    state_t                state;
    logic [ID_W-1:0]       gnt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      beat_cnt;

    logic [ID_W-1:0]       arb_winner;
    logic                  arb_any;
    logic [ADD_IN_W-1:0]   beat_data;
    logic [ADD_OUT_W-1:0]  beat_pop;
    logic                  gnt_valid;
    logic [ACC_W-1:0]      acc_next;
    logic                  last_beat;
    logic [ID_W-1:0]       gnt_inc;

    rr_arbiter_nreq #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .winner    (arb_winner),
        .any_valid (arb_any)
    );

    // gnt-indexed mux; a compare loop keeps out-of-range gnt values harmless
    // when NREQ is not a power of two.
    always_comb begin
        beat_data = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == ID_W'(i)) begin
                beat_data = req_data[i*ADD_IN_W +: ADD_IN_W];
                gnt_valid = req_valid[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state == ACCUM) && (gnt == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    adder_10to4 u_adder (
        .bits  (beat_data),
        .count (beat_pop)
    );

    assign acc_next  = acc + ACC_W'(beat_pop);
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign gnt_inc   = (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + ID_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
`ifdef POPCNT_THRESH_EN
            out_fire  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt      <= arb_winner;
                        acc      <= '0;
                        beat_cnt <= '0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (gnt_valid) begin
                        acc      <= acc_next;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (last_beat) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                            out_id    <= gnt;
`ifdef POPCNT_THRESH_EN
                            // thresh only matters on the final beat
                            out_fire  <= (acc_next >= thresh);
`endif
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= gnt_inc;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
